// File: rtl/coin_key_filter.sv
// Coin-input conditioner for the cola vending FSM.
// Two raw active-low push-keys (key[0] = 1 yuan, key[1] = 0.5 yuan) are
// synchronised, debounced and turned into single-cycle pulses, one per
// accepted press. The two pulses are never high in the same cycle, so the
// downstream FSM never drops a coin to its branch priority.
module coin_key_filter #(
   parameter int unsigned DEBOUNCE_CNT = 32'd1_000_000,
   parameter int unsigned CNT_W        = 20
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] key_i,
   output logic       key_1_o,
   output logic       key0_5_o,
   output logic [1:0] key_level_o
);

   typedef enum logic [1:0] {
      ST_UP,
      ST_DN_FILT,
      ST_DOWN,
      ST_UP_FILT
   } chan_state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CNT - 32'd1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic [1:0]       sync1_q;
   logic [1:0]       sync2_q;
   chan_state_e      state_q [2];
   logic [CNT_W-1:0] cnt_q   [2];
   logic [1:0]       req_q;
   logic [1:0]       level_q;
   logic             key1_q;
   logic             key05_q;
   logic             pending_q;
   logic             key1_d;
   logic             key05_d;
   logic             pending_d;

   // Two-flop synchroniser per key; resets to the released level (1).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   // Independent debounce FSM per channel: a level must hold for
   // DEBOUNCE_CNT consecutive cycles before it is accepted; a press raises
   // a one-cycle request and the debounced level, a release drops the level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= ST_UP;
            cnt_q[i]   <= '0;
         end
         req_q   <= 2'b00;
         level_q <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            req_q[i] <= 1'b0;
            case (state_q[i])
               ST_UP: begin
                  if (!sync2_q[i]) begin
                     state_q[i] <= ST_DN_FILT;
                     cnt_q[i]   <= CntOne;
                  end
               end
               ST_DN_FILT: begin
                  if (sync2_q[i]) begin
                     state_q[i] <= ST_UP;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == CntLast) begin
                     state_q[i] <= ST_DOWN;
                     cnt_q[i]   <= '0;
                     req_q[i]   <= 1'b1;
                     level_q[i] <= 1'b1;
                  end else if (cnt_q[i] != '1) begin
                     cnt_q[i] <= cnt_q[i] + CntOne;
                  end
               end
               ST_DOWN: begin
                  if (sync2_q[i]) begin
                     state_q[i] <= ST_UP_FILT;
                     cnt_q[i]   <= CntOne;
                  end
               end
               ST_UP_FILT: begin
                  if (!sync2_q[i]) begin
                     state_q[i] <= ST_DOWN;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == CntLast) begin
                     state_q[i] <= ST_UP;
                     cnt_q[i]   <= '0;
                     level_q[i] <= 1'b0;
                  end else if (cnt_q[i] != '1) begin
                     cnt_q[i] <= cnt_q[i] + CntOne;
                  end
               end
               default: begin
                  state_q[i] <= ST_UP;
                  cnt_q[i]   <= '0;
               end
            endcase
         end
      end
   end

   // Collision arbitration: the 1-yuan request wins a tie and the 0.5-yuan
   // request is parked in the pending flop for one cycle.
   always_comb begin
      key1_d    = req_q[0];
      key05_d   = pending_q | (req_q[1] & ~req_q[0]);
      pending_d = req_q[0] & req_q[1];
   end

   // Registered output stage so no output depends combinationally on a key.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key1_q    <= 1'b0;
         key05_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         key1_q    <= key1_d;
         key05_q   <= key05_d;
         pending_q <= pending_d;
      end
   end

   assign key_1_o     = key1_q;
   assign key0_5_o    = key05_q;
   assign key_level_o = level_q;

endmodule

// File: tb/tb_coin_key_filter.sv
// Self-checking bench for coin_key_filter with a short debounce time.
module tb_coin_key_filter;

   localparam int unsigned DB = 8;
   localparam int unsigned CW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] key = 2'b11;
   logic       key_1;
   logic       key0_5;
   logic [1:0] key_level;

   int errors = 0;
   int checks = 0;
   int p1 = 0;
   int p05 = 0;
   int both = 0;

   typedef struct {
      logic [1:0] keyIn;
      int         cycles;
      int         expP1;
      int         expP05;
      logic [1:0] expLevel;
   } vec_t;

   vec_t vecs [10];

   coin_key_filter #(
      .DEBOUNCE_CNT(DB),
      .CNT_W       (CW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .key_i      (key),
      .key_1_o    (key_1),
      .key0_5_o   (key0_5),
      .key_level_o(key_level)
   );

   // 100 MHz-style free-running clock for simulation.
   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (key_1) p1++;
      if (key0_5) p05++;
      if (key_1 && key0_5) both++;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges counted from the edge just before the call until the chosen
   // output is first seen high; -1 if the bound expires.
   task automatic waitFor(input int which, output int n);
      n = -1;
      for (int e = 1; e <= 200; e++) begin
         @(posedge clk);
         #1;
         if ((which == 0 && key_1 === 1'b1) || (which == 1 && key0_5 === 1'b1)) begin
            n = e;
            break;
         end
      end
   endtask

   task automatic waitLevelLow0(output int n);
      n = -1;
      for (int e = 1; e <= 200; e++) begin
         @(posedge clk);
         #1;
         if (key_level[0] === 1'b0) begin
            n = e;
            break;
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      p1  = 0;
      p05 = 0;
      key = v.keyIn;
      step(v.cycles);
      checkOutput($sformatf("vec%0d_key1_pulses", idx), p1, v.expP1);
      checkOutput($sformatf("vec%0d_key05_pulses", idx), p05, v.expP05);
      checkOutput($sformatf("vec%0d_level", idx), int'(key_level), int'(v.expLevel));
   endtask

   initial begin
      int n;

      vecs[0] = '{2'b11, 20, 0, 0, 2'b00};
      vecs[1] = '{2'b10, 20, 1, 0, 2'b01};
      vecs[2] = '{2'b11, 20, 0, 0, 2'b00};
      vecs[3] = '{2'b01, 20, 0, 1, 2'b10};
      vecs[4] = '{2'b11, 20, 0, 0, 2'b00};
      vecs[5] = '{2'b01,  7, 0, 0, 2'b00};
      vecs[6] = '{2'b11, 20, 0, 0, 2'b00};
      vecs[7] = '{2'b10,  7, 0, 0, 2'b00};
      vecs[8] = '{2'b11, 20, 0, 0, 2'b00};
      vecs[9] = '{2'b00, 25, 1, 1, 2'b11};

      // Reset state
      step(3);
      checkOutput("reset_key1", int'(key_1), 0);
      checkOutput("reset_key05", int'(key0_5), 0);
      checkOutput("reset_level", int'(key_level), 0);
      rst_n = 1'b1;
      step(3);

      // Table-driven presses, releases and glitches
      for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
      key = 2'b11;
      step(20);

      // T1 clean press latency
      p1 = 0; p05 = 0;
      key = 2'b10;
      waitFor(0, n);
      checkOutput("t1_latency", n, 11);
      step(1);
      checkOutput("t1_pulse_width", int'(key_1), 0);
      step(28);
      checkOutput("t1_level", int'(key_level), 1);
      checkOutput("t1_p1", p1, 1);
      checkOutput("t1_p05", p05, 0);
      key = 2'b11;
      step(20);

      // T2 bounce on key[1]
      p05 = 0;
      for (int s = 0; s < 10; s++) begin
         key[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
         step(3);
      end
      key[1] = 1'b0;
      waitFor(1, n);
      checkOutput("t2_latency", n, 11);
      step(10);
      checkOutput("t2_p05", p05, 1);
      key = 2'b11;
      step(20);

      // T3 simultaneous press
      p1 = 0; p05 = 0; both = 0;
      key = 2'b00;
      waitFor(0, n);
      checkOutput("t3_key1_latency", n, 11);
      checkOutput("t3_key05_not_with_key1", int'(key0_5), 0);
      step(1);
      checkOutput("t3_key05_next", int'(key0_5), 1);
      checkOutput("t3_key1_gone", int'(key_1), 0);
      step(10);
      checkOutput("t3_both", both, 0);
      checkOutput("t3_p1", p1, 1);
      checkOutput("t3_p05", p05, 1);
      key = 2'b11;
      step(20);

      // T4 long hold then release bounce
      p1 = 0;
      key = 2'b10;
      step(100);
      checkOutput("t4_p1_hold", p1, 1);
      checkOutput("t4_level_hold", int'(key_level), 1);
      key[0] = 1'b1; step(1);
      key[0] = 1'b0; step(1);
      key[0] = 1'b1; step(1);
      key[0] = 1'b0; step(1);
      checkOutput("t4_level_bounce", int'(key_level), 1);
      key[0] = 1'b1;
      waitLevelLow0(n);
      checkOutput("t4_release_latency", n, 10);
      step(10);
      checkOutput("t4_p1_total", p1, 1);

      // T5 reset mid-filter and mid-hold
      p1 = 0;
      key = 2'b10;
      step(4);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_key1", int'(key_1), 0);
      checkOutput("t5_rst_level", int'(key_level), 0);
      step(2);
      rst_n = 1'b1;
      waitFor(0, n);
      checkOutput("t5_latency", n, 11);
      step(5);
      checkOutput("t5_level_held", int'(key_level), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_hold_level", int'(key_level), 0);
      step(2);
      rst_n = 1'b1;
      waitFor(0, n);
      checkOutput("t5_held_repress", n, 11);
      key = 2'b11;
      step(20);

      checkOutput("no_coincident_pulses", both, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
